// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Load/store unit between a pipeline request port and a
//               word-wide data memory. Supports LW/LH/LHU/LB/LBU/SW/SH/SB.
//               Sub-word stores are done as read-modify-write. Misaligned or
//               out-of-range requests are answered with an error and never
//               touch memory.
// Ports       : clk/rst_n                   clock, async active-low reset
//               req_valid/req_ready         request handshake (ready in IDLE)
//               req_op/req_addr/req_wdata   request op code, byte addr, data
//               resp_valid/rdata/err        one-cycle response pulse + result
//               mem_addr/wdata/read/write   word-wide memory interface
//               mem_rdata                   memory read word (little-endian)
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter logic [31:0] DATA_LIMIT = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD1   = 3'd1,
        ST_RD2   = 3'd2,
        ST_WR    = 3'd3,
        ST_WHOLD = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;         // byte lane of the accepted address
    logic [15:0] wdata_q;        // only the sub-word part is needed for RMW
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic        req_err;
    logic        op_is_load;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] merged;

    assign accept     = (state_q == ST_IDLE) && req_valid;
    assign op_is_load = (op_q <= OP_LBU);

    // Alignment and range check on the live request; only consumed at acceptance.
    always_comb begin
        req_err = 1'b0;
        case (req_op)
            OP_LW, OP_SW:         req_err = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: req_err = req_addr[0];
            default:              req_err = 1'b0;
        endcase
        if (req_addr > (DATA_LIMIT - 32'd4)) begin
            req_err = 1'b1;
        end
    end

    // Lane extraction / extension of the word returned by memory.
    always_comb begin
        ld_byte = mem_rdata[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'h0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'h0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // Merge of the new byte/halfword into the word read during RMW.
    always_comb begin
        merged = mem_rdata;
        if (op_q == OP_SB) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)              state_d = ST_RESP;
                    else if (req_op == OP_SW) state_d = ST_WR;
                    else                      state_d = ST_RD1;
                end
            end
            ST_RD1:   state_d = ST_RD2;
            ST_RD2:   state_d = op_is_load ? ST_RESP : ST_WR;
            ST_WR:    state_d = ST_WHOLD;
            ST_WHOLD: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch, memory address/data registers and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= OP_LW;
            lane_q       <= 2'b00;
            wdata_q      <= 16'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= req_op;
                lane_q     <= req_addr[1:0];
                wdata_q    <= req_wdata[15:0];
                mem_addr_q <= {req_addr[31:2], 2'b00};
                if ((req_op == OP_SW) && !req_err) begin
                    mem_wdata_q <= req_wdata;
                end
                if (req_err) begin
                    resp_rdata_q <= 32'h0;
                    resp_err_q   <= 1'b1;
                end
            end
            if (state_q == ST_RD2) begin
                if (op_is_load) begin
                    resp_rdata_q <= ld_data;
                    resp_err_q   <= 1'b0;
                end else begin
                    mem_wdata_q <= merged;
                end
            end
            // Every store passes through WHOLD on its way to RESP.
            if (state_q == ST_WHOLD) begin
                resp_rdata_q <= 32'h0;
                resp_err_q   <= 1'b0;
            end
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_read   = (state_q == ST_RD1) || (state_q == ST_RD2);
    assign mem_write  = (state_q == ST_WR);

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               word-wide memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Activity counters, written only by the monitor.
    int          rd_cyc   = 0;
    int          wr_cyc   = 0;
    int          both_cyc = 0;
    int          resp_cyc = 0;
    logic [31:0] last_wd  = 32'h0;

    // Memory model with a preload port.
    logic [31:0] mem [0:63];
    logic        pl_en   = 1'b0;
    logic [5:0]  pl_idx  = 6'd0;
    logic [31:0] pl_data = 32'h0;

    load_store_unit #(.DATA_LIMIT(32'h0000_3000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = mem_read ? mem[mem_addr[7:2]] : 32'h0;

    always @(negedge clk) begin
        if (mem_read)               rd_cyc   <= rd_cyc + 1;
        if (mem_write)              wr_cyc   <= wr_cyc + 1;
        if (mem_read && mem_write)  both_cyc <= both_cyc + 1;
        if (resp_valid)             resp_cyc <= resp_cyc + 1;
        if (mem_write)              last_wd  <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        pl_idx  = idx;
        pl_data = data;
        pl_en   = 1'b1;
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    // One transaction, called one step after a rising edge with the DUT idle.
    task automatic xact(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, input int exp_lat, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_rds, input int exp_wrs);
        int rd0, wr0, lat;
        rd0 = rd_cyc;
        wr0 = wr_cyc;
        check_eq({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        req_op = op; req_addr = a; req_wdata = d; req_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs after acceptance: the unit must use latched values.
        req_valid = 1'b0; req_op = OP_SB; req_addr = 32'h0000_0039; req_wdata = 32'h5A5A_5A5A;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_rdata"}, resp_rdata, exp_rd);
        check_eq({tag, "_err"}, {31'h0, resp_err}, {31'h0, exp_err});
        check_eq({tag, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
        @(posedge clk); #1;
        check_eq({tag, "_pulse_end"}, {31'h0, resp_valid}, 32'h0);
        check_eq({tag, "_rdata_hold"}, resp_rdata, exp_rd);
        check_eq({tag, "_read_cycles"}, rd_cyc - rd0, exp_rds);
        check_eq({tag, "_write_cycles"}, wr_cyc - wr0, exp_wrs);
    endtask

    initial begin
        int n, lat, r0, w0;
        rst_n = 1'b0; req_valid = 1'b0; req_op = OP_LW; req_addr = 32'h0; req_wdata = 32'h0;
        #3;
        check_eq("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check_eq("rst_resp_err",   {31'h0, resp_err},   32'h0);
        check_eq("rst_rw",         {30'h0, mem_read, mem_write}, 32'h0);
        check_eq("rst_resp_rdata", resp_rdata, 32'h0);
        check_eq("rst_mem_addr",   mem_addr,   32'h0);
        check_eq("rst_mem_wdata",  mem_wdata,  32'h0);
        preload(6'd4, 32'h8081_7F02);
        preload(6'd5, 32'hAABB_CCDD);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rel_ready", {31'h0, req_ready}, 32'h1);

        // Loads on word 0x10 = 0x8081_7F02.
        xact("lb12",  OP_LB,  32'h12, 32'h0, 3, 32'hFFFF_FF81, 1'b0, 2, 0);
        xact("lbu12", OP_LBU, 32'h12, 32'h0, 3, 32'h0000_0081, 1'b0, 2, 0);
        xact("lh12",  OP_LH,  32'h12, 32'h0, 3, 32'hFFFF_8081, 1'b0, 2, 0);
        xact("lhu10", OP_LHU, 32'h10, 32'h0, 3, 32'h0000_7F02, 1'b0, 2, 0);
        xact("lb11",  OP_LB,  32'h11, 32'h0, 3, 32'h0000_007F, 1'b0, 2, 0);
        xact("lw10",  OP_LW,  32'h10, 32'h0, 3, 32'h8081_7F02, 1'b0, 2, 0);

        // Byte store RMW.
        xact("sb11", OP_SB, 32'h11, 32'h0000_00AA, 5, 32'h0, 1'b0, 2, 1);
        check_eq("sb11_wdata", last_wd, 32'h8081_AA02);
        check_eq("sb11_mem",   mem[4],  32'h8081_AA02);

        // Halfword store RMW into the upper lane.
        xact("sh16", OP_SH, 32'h16, 32'hFFFF_1234, 5, 32'h0, 1'b0, 2, 1);
        check_eq("sh16_mem", mem[5], 32'h1234_CCDD);

        // Error cases: no memory activity, one-cycle latency.
        xact("err_lw06",   OP_LW, 32'h0006, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        xact("err_sh13",   OP_SH, 32'h0013, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        xact("err_sw3000", OP_SW, 32'h3000, 32'h1, 1, 32'h0, 1'b1, 0, 0);
        // Last legal word, and the error flag clearing on the next response.
        xact("sw2ffc", OP_SW, 32'h2FFC, 32'h1357_9BDF, 3, 32'h0, 1'b0, 0, 1);
        check_eq("sw2ffc_wdata", last_wd, 32'h1357_9BDF);

        // Back-to-back SW then LW with req_valid held high.
        req_op = OP_SW; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
        @(posedge clk); #1;
        req_op = OP_LW; req_wdata = 32'h0;
        n = 0;
        while (!req_ready && n < 10) begin
            n++;
            @(posedge clk); #1;
        end
        check_eq("b2b_ready_low", n, 3);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("b2b_lw_latency", lat, 3);
        check_eq("b2b_lw_rdata", resp_rdata, 32'hCAFE_F00D);
        @(posedge clk); #1;

        // Reset during RD2 of an SH read-modify-write.
        r0 = resp_cyc; w0 = wr_cyc;
        req_op = OP_SH; req_addr = 32'h14; req_wdata = 32'h0000_BEEF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_rd2_read_hi", {31'h0, mem_read}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_rd2_read_lo", {31'h0, mem_read}, 32'h0);
        check_eq("rst_rd2_write_lo", {31'h0, mem_write}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rd2_no_resp",  resp_cyc - r0, 0);
        check_eq("rst_rd2_no_write", wr_cyc - w0, 0);
        check_eq("rst_rd2_mem",      mem[5], 32'h1234_CCDD);
        check_eq("rst_rd2_ready",    {31'h0, req_ready}, 32'h1);

        check_eq("rw_overlap_cycles", both_cyc, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_LIMIT, default 32'h0000_3000, meaning the first byte address outside the data region; data addresses are 0x0000 to DATA_LIMIT-1.
REQ-002 SHALL have ports, clock and reset first:
  clk         input   1   single clock; all state updates on rising edge.
  rst_n       input   1   reset, asynchronous, active-low.
  req_valid   input   1   pipeline request present.
  req_ready   output  1   unit can accept a request.
  req_op      input   3   0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
  req_addr    input   32  byte address.
  req_wdata   input   32  store data; SH uses [15:0], SB uses [7:0].
  resp_valid  output  1   one-cycle completion pulse.
  resp_rdata  output  32  load result, extended to 32 bits.
  resp_err    output  1   qualifies resp_valid: misaligned or out-of-range access.
  mem_addr    output  32  word address to data memory, bits [1:0] always 0.
  mem_wdata   output  32  word write data to memory.
  mem_read    output  1   memory read enable.
  mem_write   output  1   memory write enable, level-sensitive.
  mem_rdata   input   32  memory read word, little-endian: byte 0 on [7:0].

Function
REQ-003 SHALL implement states IDLE, RD1, RD2, WR, WHOLD, RESP.
REQ-004 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid=1 in IDLE.
REQ-005 SHALL latch req_op, req_addr and req_wdata at acceptance; later input changes SHALL have no effect.
REQ-006 SHALL flag an error when LW/SW addr[1:0]!=0, or LH/LHU/SH addr[0]!=0, or req_addr>DATA_LIMIT-4 (unsigned).
REQ-007 On an error request, SHALL go IDLE->RESP with resp_err=1 and resp_rdata=0, and SHALL assert no mem_read or mem_write.
REQ-008 SHALL drive mem_addr={addr[31:2],2'b00} from the acceptance edge until the next acceptance; mem_addr is registered.
REQ-009 For loads, SHALL sequence IDLE->RD1->RD2->RESP, with mem_read=1 in RD1 and RD2 only, and capture mem_rdata on the RD2->RESP edge (read path has 1 ns enable delay).
REQ-010 For SW, SHALL sequence IDLE->WR->WHOLD->RESP, with mem_wdata=req_wdata, and mem_write=1 in WR only.
REQ-011 In WHOLD, SHALL hold mem_addr and mem_wdata stable with mem_write=0 (memory byte writes complete up to 4 ns after enable).
REQ-012 For SH/SB, SHALL perform read-modify-write IDLE->RD1->RD2->WR->WHOLD->RESP: merge the new halfword or byte into the captured word at lane addr[1:0] (SH lane addr[1]); other bytes are unchanged.
REQ-013 SHALL produce load results as follows:
  - LB/LH: sign-extend the selected lane.
  - LBU/LHU: zero-extend the selected lane.
  - LW: the full word.
REQ-014 SHALL pulse resp_valid for exactly one cycle in RESP, then return to IDLE; there is no response backpressure.
REQ-015 SHALL hold resp_rdata and resp_err until the next RESP; stores SHALL return resp_rdata=0.
REQ-016 Latency from the acceptance edge to the resp_valid rising edge SHALL be:
  - error: 1 cycle
  - load: 3 cycles
  - SW: 3 cycles
  - SH/SB: 5 cycles
REQ-017 mem_read and mem_write SHALL never be 1 in the same cycle.

Reset
REQ-018 While rst_n=0, SHALL immediately force:
  - state=IDLE
  - req_ready=1 once released
  - resp_valid=0, resp_err=0, mem_read=0, mem_write=0
  - resp_rdata=0, mem_addr=0, mem_wdata=0
REQ-019 Reset mid-transaction SHALL abandon it with no response; a partial RMW issues no write.

Verification
REQ-020 Memory word 0x0010=0x8081_7F02:
  - LB 0x0012 -> resp_rdata 0xFFFF_FF81.
  - LBU 0x0012 -> 0x0000_0081.
  - LH 0x0012 -> 0xFFFF_8081.
  - LHU 0x0010 -> 0x0000_7F02.
  - Each response arrives 3 cycles after acceptance.
REQ-021 SB 0x0011 with data 0x0000_00AA on word 0x8081_7F02 -> mem_wdata 0x8081_AA02, one mem_write cycle, resp_valid 5 cycles after acceptance, resp_err=0.
REQ-022 The following SHALL give resp_err=1 one cycle after acceptance, with mem_read and mem_write never asserted:
  - LW 0x0006
  - SH 0x0013
  - SW 0x3000
REQ-023 Hold req_valid=1 with SW 0x0020 then LW 0x0020 -> req_ready=0 for 3 cycles between acceptances, and the LW returns the stored data.
REQ-024 Assert rst_n=0 during RD2 of SH 0x0014 -> mem_read falls with no clock edge, no mem_write, no resp_valid, and memory word 0x0014 is unchanged.
REQ-025 Check every cycle of the above scenarios: mem_read and mem_write are never both 1.
